// File: rtl/word_narrower_pkg.sv
// Shared types and constants for the 16-to-8 word narrower.
// The optional compact mode is selected with the NARROWER_COMPACT_EN macro.
package word_narrower_pkg;

    localparam int unsigned WORD_W  = 16;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned STATE_W = 2;

    // FSM encoding, kept as plain constants so older tools can share it
    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_LOW  = 2'd1;
    localparam logic [STATE_W-1:0] ST_HIGH = 2'd2;

    // One beat on the byte side: payload plus end-of-word marker
    typedef struct packed {
        logic [BYTE_W-1:0] data;
        logic              last;
    } byte_beat_t;

    // True when the word is a zero-extended byte
    function automatic logic upper_zero(input logic [WORD_W-1:0] word);
        return word[WORD_W-1:BYTE_W] == BYTE_W'(0);
    endfunction

endpackage

// File: rtl/word_narrower_if.sv
// Word-in / byte-out handshake bundle for word_narrower.
// master = producer/consumer side, slave = the narrower itself.
interface word_narrower_if;
    import word_narrower_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_word;
    logic              out_valid;
    logic              out_ready;
    logic [BYTE_W-1:0] out_byte;
    logic              out_last;
    logic [WORD_W-1:0] word_count;

    modport master (
        output in_valid, in_word, out_ready,
        input  in_ready, out_valid, out_byte, out_last, word_count
    );

    modport slave (
        input  in_valid, in_word, out_ready,
        output in_ready, out_valid, out_byte, out_last, word_count
    );

endinterface

// File: rtl/word_narrower_byte_select.sv
// Picks the low or high byte of a held word; purely combinational.
module word_narrower_byte_select
    import word_narrower_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic              sel_high,
    output logic [BYTE_W-1:0] data_c
);

    assign data_c = sel_high ? word[WORD_W-1:BYTE_W] : word[BYTE_W-1:0];

endmodule

// File: rtl/word_narrower.sv
// Narrows 16-bit words into a low-byte-first 8-bit stream with a word counter.
// Define NARROWER_COMPACT_EN to emit zero-extended words as a single byte.
module word_narrower
    import word_narrower_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    word_narrower_if.slave  bus
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_next;
    logic [WORD_W-1:0]  hold_word;
    logic [WORD_W-1:0]  hold_next;
    logic [WORD_W-1:0]  count;
    logic               count_inc_c;
    logic               compact_c;
    logic               ready_c;
    logic               valid_c;
    logic               last_c;
    logic [BYTE_W-1:0]  sel_byte_c;
    byte_beat_t         beat_c;

`ifdef NARROWER_COMPACT_EN
    assign compact_c = upper_zero(hold_word);
`else
    assign compact_c = 1'b0;
`endif

    word_narrower_byte_select u_byte_select (
        .word     (hold_word),
        .sel_high (state == ST_HIGH),
        .data_c   (sel_byte_c)
    );

    // Next-state, capture and handshake decode
    always_comb begin
        state_next  = state;
        hold_next   = hold_word;
        count_inc_c = 1'b0;
        ready_c     = 1'b0;
        valid_c     = 1'b0;
        last_c      = 1'b0;

        case (state)
            ST_IDLE: begin
                ready_c = 1'b1;
                if (bus.in_valid) begin
                    hold_next  = bus.in_word;
                    state_next = ST_LOW;
                end
            end
            ST_LOW, ST_HIGH: begin
                valid_c = 1'b1;
                last_c  = (state == ST_HIGH) || compact_c;
                if (!last_c) begin
                    if (bus.out_ready) begin
                        state_next = ST_HIGH;
                    end
                end else begin
                    // Final byte: the slot frees this cycle only if the consumer takes it
                    ready_c = bus.out_ready;
                    if (bus.out_ready) begin
                        count_inc_c = 1'b1;
                        if (bus.in_valid) begin
                            hold_next  = bus.in_word;
                            state_next = ST_LOW;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            hold_word <= '0;
            count     <= '0;
        end else begin
            state     <= state_next;
            hold_word <= hold_next;
            if (count_inc_c) begin
                count <= count + WORD_W'(1);
            end
        end
    end

    assign beat_c.data = sel_byte_c;
    assign beat_c.last = last_c;

    assign bus.in_ready   = ready_c && !reset;
    assign bus.out_valid  = valid_c;
    assign bus.out_byte   = beat_c.data;
    assign bus.out_last   = beat_c.last;
    assign bus.word_count = count;

endmodule
